// File: rtl/i2c_slv_rx.sv
`timescale 1ns/1ps
// I2C write-only target: receives bytes addressed to SLV_ADDR and hands them to a consumer.
// Latency: pad edge to bus event 2 + FILT_CYCLES clocks; data_valid_o 1 clock after bit-8 SCL rise.
// Backpressure: one-byte output register; a byte arriving while it is still full is NACKed (ovf_o).
//
// Ports:
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   scl_i, sda_i        raw I2C pad inputs (synchronised and glitch-filtered inside)
//   sda_oe_o            open-drain pull-down enable for SDA (ACK)
//   data_o/data_valid_o/data_ready_i   received byte, valid/ready handshake
//   first_o             data_o is the first data byte after the address
//   busy_o              target currently addressed
//   stop_o, ovf_o       single-cycle pulses: addressed STOP, byte dropped on full register
module i2c_slv_rx #(
   parameter logic [6:0]  SLV_ADDR    = 7'h50,
   parameter int unsigned FILT_CYCLES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   output logic [7:0] data_o,
   output logic       data_valid_o,
   input  logic       data_ready_i,
   output logic       first_o,
   output logic       busy_o,
   output logic       stop_o,
   output logic       ovf_o
);

   localparam logic [2:0] FILT_LAST = 3'(FILT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_WAIT_STOP
   } state_t;

   // ------------------------------------------------------------------
   // Input conditioning. Index 0 = SCL, index 1 = SDA.
   // Everything presets to 1 so reset looks like an idle bus.
   // ------------------------------------------------------------------
   logic [1:0]      sync0_q;
   logic [1:0]      sync1_q;
   logic [1:0]      filt_q;
   logic [1:0]      filt_d;
   logic [1:0][2:0] fcnt_q;
   logic [1:0][2:0] fcnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync0_q <= 2'b11;
         sync1_q <= 2'b11;
         filt_q  <= 2'b11;
         fcnt_q  <= '0;
      end else begin
         sync0_q <= {sda_i, scl_i};
         sync1_q <= sync0_q;
         filt_q  <= filt_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // The filtered level only follows after FILT_CYCLES consecutive samples
   // that disagree with it; any agreeing sample restarts the count.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync1_q[i] != filt_q[i]) begin
            if (fcnt_q[i] == FILT_LAST) begin
               filt_d[i] = sync1_q[i];
            end else begin
               fcnt_d[i] = fcnt_q[i] + 3'd1;
            end
         end
      end
   end

   logic scl_rise;
   logic scl_fall;
   logic sda_rise;
   logic sda_fall;
   logic start_evt;
   logic stop_evt;

   assign scl_rise  =  filt_d[0] & ~filt_q[0];
   assign scl_fall  = ~filt_d[0] &  filt_q[0];
   assign sda_rise  =  filt_d[1] & ~filt_q[1];
   assign sda_fall  = ~filt_d[1] &  filt_q[1];
   // SCL and SDA edges never share a cycle, so filt_q[0] is the stable SCL level here.
   assign start_evt = sda_fall & filt_q[0];
   assign stop_evt  = sda_rise & filt_q[0];

   // ------------------------------------------------------------------
   // Protocol FSM
   // ------------------------------------------------------------------
   state_t     state_q,      state_d;
   logic [3:0] bit_cnt_q,    bit_cnt_d;
   logic [7:0] shift_q,      shift_d;
   logic       oe_q,         oe_d;
   logic [7:0] data_q,       data_d;
   logic       valid_q,      valid_d;
   logic       first_q,      first_d;
   logic       first_pend_q, first_pend_d;
   logic       busy_q,       busy_d;
   logic       stop_q,       stop_d;
   logic       ovf_q,        ovf_d;
   logic [7:0] shift_nxt;
   logic       addr_hit;
   logic       reg_free;

   assign shift_nxt = {shift_q[6:0], filt_q[1]};
   assign addr_hit  = (shift_nxt[7:1] == SLV_ADDR) && !shift_nxt[0];
   // A handshake in the completion cycle frees the register in time for the new byte.
   assign reg_free  = !valid_q || data_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         oe_q         <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         first_q      <= 1'b0;
         first_pend_q <= 1'b0;
         busy_q       <= 1'b0;
         stop_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         oe_q         <= oe_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         first_q      <= first_d;
         first_pend_q <= first_pend_d;
         busy_q       <= busy_d;
         stop_q       <= stop_d;
         ovf_q        <= ovf_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      oe_d         = oe_q;
      data_d       = data_q;
      valid_d      = valid_q;
      first_d      = first_q;
      first_pend_d = first_pend_q;
      busy_d       = busy_q;
      stop_d       = 1'b0;
      ovf_d        = 1'b0;

      if (valid_q && data_ready_i) begin
         valid_d = 1'b0;
      end

      if (start_evt) begin
         state_d   = ST_ADDR;
         bit_cnt_d = '0;
         oe_d      = 1'b0;
         busy_d    = 1'b0;
      end else if (stop_evt) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
         stop_d  = busy_q;
      end else begin
         case (state_q)
            ST_ADDR: begin
               // bit_cnt_q == 8 means the byte is complete and the ACK is pending.
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = shift_nxt;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7 && !addr_hit) begin
                     state_d = ST_WAIT_STOP;
                  end
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  oe_d    = 1'b1;
                  state_d = ST_ADDR_ACK;
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  oe_d         = 1'b0;
                  busy_d       = 1'b1;
                  first_pend_d = 1'b1;
                  bit_cnt_d    = '0;
                  state_d      = ST_DATA;
               end
            end
            ST_DATA: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = shift_nxt;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (reg_free) begin
                        data_d       = shift_nxt;
                        valid_d      = 1'b1;
                        first_d      = first_pend_q;
                        first_pend_d = 1'b0;
                     end else begin
                        ovf_d   = 1'b1;
                        state_d = ST_WAIT_STOP;
                     end
                  end
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  oe_d    = 1'b1;
                  state_d = ST_DATA_ACK;
               end
            end
            ST_DATA_ACK: begin
               if (scl_fall) begin
                  oe_d      = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = ST_DATA;
               end
            end
            default: begin
               // ST_IDLE and ST_WAIT_STOP only leave on START/STOP.
            end
         endcase
      end
   end

   // START/STOP release the pad in the detection cycle, ahead of the register.
   assign sda_oe_o     = oe_q & ~(start_evt | stop_evt);
   assign data_o       = data_q;
   assign data_valid_o = valid_q;
   assign first_o      = first_q;
   assign busy_o       = busy_q;
   assign stop_o       = stop_q;
   assign ovf_o        = ovf_q;

endmodule

// File: doc/i2c_slv_rx.md
# i2c_slv_rx

I2C target (slave) receiver that answers a single 7-bit address on the PMS I2C bus and turns each write transaction into a byte stream for the on-chip consumer, normally the L2 write DMA. It is the responder for the bus-master stimulus used in the I2C dump benches. It synchronises SCL and SDA, detects START and STOP, and shifts in the address and data bytes. It drives ACK or NACK on the open-drain SDA line and hands each accepted byte over a valid/ready interface. It is write-only: a read request is NACKed.

## Interface
- SLV_ADDR, 7'h50, 7-bit address this target responds to
- FILT_CYCLES, 2, number of consecutive equal synchronised samples required before a filtered SCL/SDA level changes (1..7)
- clk_i  in  1  system clock; must be at least 16x the SCL frequency
- rst_i  in  1  asynchronous, active-high reset
- scl_i  in  1  SCL pad input
- sda_i  in  1  SDA pad input
- sda_oe_o  out  1  1 = pull SDA low (open-drain); pad drives 0 when set, tristate otherwise
- data_o  out  8  received data byte, MSB first on the wire
- data_valid_o  out  1  data_o holds an unconsumed byte
- data_ready_i  in  1  consumer accepts data_o on the cycle where valid and ready are both high
- first_o  out  1  data_o is the first data byte after the address of the current transaction
- busy_o  out  1  target is addressed (between the address ACK and STOP/START)
- stop_o  out  1  one-cycle pulse on a STOP that ends a transaction addressed to this target
- ovf_o  out  1  one-cycle pulse when a byte is NACKed because the output register is full

## Operation
- **Input conditioning.** scl_i and sda_i go through a 2-FF synchroniser, then the FILT_CYCLES glitch filter.
  - Edge events scl_rise, scl_fall, sda_rise and sda_fall come from the filtered levels.
- **Bus events.**
  - START: sda_fall while filtered SCL = 1.
  - STOP: sda_rise while filtered SCL = 1.
  - Both are valid in every state. START (including a repeated START) moves to ADDR with the bit counter at 0. STOP moves to IDLE.
- **FSM states.** IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP.
  - ADDR: shift SDA in on each scl_rise. After the 8th bit, compare bits [7:1] with SLV_ADDR; bit 0 is R/W.
    - If the address matches and R/W = 0: on the next scl_fall, assert sda_oe_o and go to ADDR_ACK.
    - Otherwise (address mismatch, or R/W = 1): do not drive SDA and go to WAIT_STOP.
  - ADDR_ACK: on scl_fall, release SDA, set busy_o and go to DATA.
  - DATA: shift 8 bits on scl_rise. At the 8th scl_rise, check the output register.
    - Register empty: load data_o, set data_valid_o, set first_o if this is the first data byte, and drive ACK on the next scl_fall.
    - Register still valid: drop the byte, pulse ovf_o, leave SDA undriven (NACK) and go to WAIT_STOP.
  - DATA_ACK: on scl_fall, release SDA and return to DATA.
  - WAIT_STOP: ignore SCL and wait for STOP or START.
- **Output register.** data_valid_o clears on a valid & ready handshake. The byte stays valid across STOP.
- **stop_o.** Pulses only if busy_o was set when the STOP arrived. busy_o clears on STOP or START.
- **SDA release rule.** SDA is never driven while SCL is high except during the ACK bit. Any START or STOP releases sda_oe_o the same cycle it is detected.

## Timing
- **Reset values.** sda_oe_o = 0, data_o = 0, data_valid_o = 0, first_o = 0, busy_o = 0, stop_o = 0, ovf_o = 0. FSM in IDLE, filters preset to 1 (bus idle).
- **Pad-to-event latency.** 2 (sync) + FILT_CYCLES cycles from a pad edge to the corresponding event.
- **Byte latency.** data_valid_o rises 1 cycle after the scl_rise event of bit 8.
- **ACK timing.** sda_oe_o rises 1 cycle after the scl_fall event following bit 8, and falls 1 cycle after the next scl_fall event.
- **Simultaneous handshake.** A handshake in the same cycle as a byte completion counts as the register being empty: the new byte is ACKed.
- **Mid-transaction reset.** rst_i releases SDA immediately (asynchronous) and discards a partial byte.
- **Event precedence.** A START or STOP in the same cycle as scl_rise or scl_fall cannot occur, because the filtered edges are distinct. If it does, START/STOP wins.

## Test plan
- Write addr 0x50, then 0xDE, 0xAD, 0xBE, STOP, with ready tied 1 → 4 ACKs, three handshakes in order, first_o only with 0xDE, one stop_o pulse, busy_o low after.
- Address 0x51 write, then 0x12 → SDA never driven, no data_valid_o, no stop_o.
- Addr 0x50 with R/W = 1 → NACK on the address, FSM in WAIT_STOP, nothing output.
- Ready held 0, write 0x11 then 0x22 → 0x11 ACKed and held; 0x22 NACKed with one ovf_o pulse; data_o stays 0x11 until ready.
- Write 0xAA, repeated START, addr 0x50, 0xBB → both bytes delivered, first_o set on both, single stop_o at the final STOP.
- Assert rst_i during the ACK bit of byte 2 → sda_oe_o drops the same cycle, outputs return to reset values, and the next full transaction is received correctly.
